// File: rtl/can_rx_sequencer_if.sv
// Bit-stream and decoder-control bundle between bit timing/decoder and can_rx_sequencer.
// Optional stuff_err_cnt is present only when CAN_RX_SEQ_STUFF_CNT_EN is defined.
interface can_rx_sequencer_if;
    logic        bit_valid;
    logic        bit_in;
    logic        crc_freeze;
    logic        destuff_off;
    logic        frame_done;
    logic        dec_sample;
    logic        dec_bit;
    logic [14:0] crc_reg;
    logic        crc_valid;
    logic        stuff_error;
    logic        bus_idle;
    logic [2:0]  seq_state;
`ifdef CAN_RX_SEQ_STUFF_CNT_EN
    logic [7:0]  stuff_err_cnt;
`endif

    modport master (
        output bit_valid, bit_in, crc_freeze, destuff_off, frame_done,
`ifdef CAN_RX_SEQ_STUFF_CNT_EN
        input  stuff_err_cnt,
`endif
        input  dec_sample, dec_bit, crc_reg, crc_valid, stuff_error, bus_idle, seq_state
    );

    modport slave (
        input  bit_valid, bit_in, crc_freeze, destuff_off, frame_done,
`ifdef CAN_RX_SEQ_STUFF_CNT_EN
        output stuff_err_cnt,
`endif
        output dec_sample, dec_bit, crc_reg, crc_valid, stuff_error, bus_idle, seq_state
    );
endinterface

// File: rtl/can_rx_sequencer.sv
// CAN receive front end: bus integration, SOF detect, destuffing and CRC-15 gating.
// Define CAN_RX_SEQ_STUFF_CNT_EN to add the saturating stuff_err_cnt output.
//
// state | meaning
// INTEG | counting recessive bits to integrate onto the bus
// IDLE  | bus idle, waiting for a dominant SOF
// FRAME | destuffing and accumulating CRC
// CRCF  | destuffing continues, CRC frozen
// TAIL  | raw pass-through until the decoder reports frame end
// ERR   | stuff violation seen, one cycle before re-integration
module can_rx_sequencer #(
    parameter int IDLE_BITS = 11,
    parameter int STUFF_LEN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    can_rx_sequencer_if.slave bus
);
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);
    localparam int RUN_W  = $clog2(STUFF_LEN + 1);

    typedef enum logic [2:0] {
        S_INTEG = 3'd0,
        S_IDLE  = 3'd1,
        S_FRAME = 3'd2,
        S_CRCF  = 3'd3,
        S_TAIL  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t            r_state;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [RUN_W-1:0]  r_run;
    logic              r_last;
    logic              r_dec_sample;
    logic              r_dec_bit;
    logic [14:0]       r_crc;
    logic              r_crc_valid;
    logic              r_stuff_error;
    logic              r_bus_idle;
`ifdef CAN_RX_SEQ_STUFF_CNT_EN
    logic [7:0]        r_stuff_err_cnt;
`endif

    logic        w_stuff_slot;
    logic [14:0] w_crc_next;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic nxt;
        nxt = b ^ c[14];
        return {c[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
    endfunction

    assign w_stuff_slot = (r_run == RUN_W'(STUFF_LEN));
    assign w_crc_next   = crc_step(r_crc, bus.bit_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_INTEG;
            r_idle_cnt      <= '0;
            r_run           <= '0;
            r_last          <= 1'b0;
            r_dec_sample    <= 1'b0;
            r_dec_bit       <= 1'b0;
            r_crc           <= '0;
            r_crc_valid     <= 1'b0;
            r_stuff_error   <= 1'b0;
            r_bus_idle      <= 1'b0;
`ifdef CAN_RX_SEQ_STUFF_CNT_EN
            r_stuff_err_cnt <= '0;
`endif
        end else begin
            r_dec_sample  <= 1'b0;
            r_stuff_error <= 1'b0;
            case (r_state)
                S_INTEG: begin
                    if (bus.bit_valid) begin
                        if (!bus.bit_in) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == IDLE_W'(IDLE_BITS - 1)) begin
                            r_idle_cnt <= '0;
                            r_bus_idle <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                S_IDLE: begin
                    if (bus.bit_valid && !bus.bit_in) begin
                        // SOF starts a fresh CRC and counts as the first bit of a run
                        r_crc        <= crc_step(15'h0000, 1'b0);
                        r_dec_sample <= 1'b1;
                        r_dec_bit    <= 1'b0;
                        r_run        <= RUN_W'(1);
                        r_last       <= 1'b0;
                        r_crc_valid  <= 1'b0;
                        r_bus_idle   <= 1'b0;
                        r_state      <= S_FRAME;
                    end
                end
                S_FRAME, S_CRCF: begin
                    if (r_state == S_CRCF && bus.destuff_off) begin
                        r_state <= S_TAIL;
                        if (bus.bit_valid) begin
                            r_dec_sample <= 1'b1;
                            r_dec_bit    <= bus.bit_in;
                        end
                    end else begin
                        if (r_state == S_FRAME && bus.crc_freeze) begin
                            r_crc_valid <= 1'b1;
                            r_state     <= S_CRCF;
                        end
                        if (bus.bit_valid) begin
                            if (w_stuff_slot) begin
                                if (bus.bit_in != r_last) begin
                                    r_run  <= RUN_W'(1);
                                    r_last <= bus.bit_in;
                                end else begin
                                    r_stuff_error <= 1'b1;
                                    r_state       <= S_ERR;
`ifdef CAN_RX_SEQ_STUFF_CNT_EN
                                    if (r_stuff_err_cnt != 8'hFF)
                                        r_stuff_err_cnt <= r_stuff_err_cnt + 8'd1;
`endif
                                end
                            end else begin
                                r_dec_sample <= 1'b1;
                                r_dec_bit    <= bus.bit_in;
                                if (r_state == S_FRAME && !bus.crc_freeze)
                                    r_crc <= w_crc_next;
                                if (bus.bit_in == r_last) begin
                                    r_run <= r_run + RUN_W'(1);
                                end else begin
                                    r_run  <= RUN_W'(1);
                                    r_last <= bus.bit_in;
                                end
                            end
                        end
                    end
                end
                S_TAIL: begin
                    if (bus.bit_valid) begin
                        r_dec_sample <= 1'b1;
                        r_dec_bit    <= bus.bit_in;
                    end
                    if (bus.frame_done)
                        r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_idle_cnt <= '0;
                    r_run      <= '0;
                    r_state    <= S_INTEG;
                end
                default: r_state <= S_INTEG;
            endcase
        end
    end

    assign bus.dec_sample  = r_dec_sample;
    assign bus.dec_bit     = r_dec_bit;
    assign bus.crc_reg     = r_crc;
    assign bus.crc_valid   = r_crc_valid;
    assign bus.stuff_error = r_stuff_error;
    assign bus.bus_idle    = r_bus_idle;
    assign bus.seq_state   = r_state;
`ifdef CAN_RX_SEQ_STUFF_CNT_EN
    assign bus.stuff_err_cnt = r_stuff_err_cnt;
`endif

endmodule

// File: tb/tb_can_rx_sequencer.sv
// Directed, table-driven bench for can_rx_sequencer; expected values are hand-computed.
module tb_can_rx_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    can_rx_sequencer_if ifc ();

    can_rx_sequencer #(.IDLE_BITS(11), .STUFF_LEN(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        bv, bi_in, fz, dso, fd;
        logic        ds, db, se, idle, cv;
        logic [14:0] crc;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic bv, bi_in, fz, dso, fd,
                                input logic ds, db, se, idle, cv,
                                input logic [14:0] crc, input logic [2:0] st);
        vec_t v;
        v = '{bv, bi_in, fz, dso, fd, ds, db, se, idle, cv, crc, st};
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic bv, bi_in, fz, dso, fd);
        ifc.bit_valid   = bv;
        ifc.bit_in      = bi_in;
        ifc.crc_freeze  = fz;
        ifc.destuff_off = dso;
        ifc.frame_done  = fd;
    endtask

    task automatic check_outs(input string name, input logic ds, db, se, idle, cv,
                              input logic [14:0] crc, input logic [2:0] st);
        n_checks++;
        if (ifc.dec_sample !== ds || ifc.dec_bit !== db || ifc.stuff_error !== se ||
            ifc.bus_idle !== idle || ifc.crc_valid !== cv || ifc.crc_reg !== crc ||
            ifc.seq_state !== st) begin
            n_errors++;
            $display("FAIL %s: got ds=%b db=%b se=%b idle=%b cv=%b crc=%h st=%0d, expected ds=%b db=%b se=%b idle=%b cv=%b crc=%h st=%0d",
                     name, ifc.dec_sample, ifc.dec_bit, ifc.stuff_error, ifc.bus_idle,
                     ifc.crc_valid, ifc.crc_reg, ifc.seq_state, ds, db, se, idle, cv, crc, st);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 check_outs("reset", 0, 0, 0, 0, 0, 15'h0000, 3'd0);

        // integration broken by a dominant bit after 10 recessive bits
        for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0000, 3'd0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0000, 3'd0);
        for (int i = 0; i < 11; i++)
            add(1, 1, 0, 0, 0, 0, 0, 0, (i == 10), 0, 15'h0000, (i == 10) ? 3'd1 : 3'd0);
        // SOF, bit 1, freeze -> 4599
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 15'h0000, 3'd2);
        add(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 15'h4599, 3'd2);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 15'h4599, 3'd3);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 15'h4599, 3'd3);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 15'h4599, 3'd4);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 15'h4599, 3'd4);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 15'h4599, 3'd1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 15'h4599, 3'd1);
        // SOF + four zeros, stuff bit dropped, then 1
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 15'h0000, 3'd2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0000, 3'd2);
        add(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 15'h4599, 3'd2);
        // freeze coincident with bit 0: bit passed, CRC unchanged
        add(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 15'h4599, 3'd3);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 15'h4599, 3'd3);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 15'h4599, 3'd3);
        add(1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 15'h4599, 3'd4);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 15'h4599, 3'd1);
        // six dominant bits -> stuff error, ERR, INTEG
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 15'h0000, 3'd2);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 15'h0000, 3'd5);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0000, 3'd0);
        for (int i = 0; i < 11; i++)
            add(1, 1, 0, 0, 0, 0, 0, 0, (i == 10), 0, 15'h0000, (i == 10) ? 3'd1 : 3'd0);
        // SOF then bit 1 with coincident freeze -> CRC stays 0
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 15'h0000, 3'd2);
        add(1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 15'h0000, 3'd3);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].bv, vecs[i].bi_in, vecs[i].fz, vecs[i].dso, vecs[i].fd);
            @(posedge clk);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].ds, vecs[i].db, vecs[i].se,
                          vecs[i].idle, vecs[i].cv, vecs[i].crc, vecs[i].st);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);

`ifdef CAN_RX_SEQ_STUFF_CNT_EN
        n_checks++;
        if (ifc.stuff_err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL stuff_err_cnt: got %0d expected 1", ifc.stuff_err_cnt);
        end
`endif

        // asynchronous reset mid-frame (currently in CRCF)
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_outs("async_reset", 0, 0, 0, 0, 0, 15'h0000, 3'd0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
